// File: rtl/rvfi_check_pkg.sv
// Shared types for the RVFI register-file consistency checker.
// Register address type, capture FSM states and the hard-zero register.
package rvfi_check_pkg;

    typedef logic [4:0] regaddr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FAILED = 2'd2
    } chk_state_e;

    localparam regaddr_t REG_X0 = 5'd0;

endpackage

// File: rtl/rvfi_shadow_reg.sv
// Shadow copy of one architectural register with in-cycle forwarding
// across retirement channels; flags rs1/rs2 reads that disagree with it.
module rvfi_shadow_reg
    import rvfi_check_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NRET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  regaddr_t           idx,
    input  logic [NRET-1:0]    rvfi_valid,
    input  logic [NRET*5-1:0]  rvfi_rd_addr,
    input  logic [NRET*5-1:0]  rvfi_rs1_addr,
    input  logic [NRET*5-1:0]  rvfi_rs2_addr,
    input  logic [NRET*XLEN-1:0] rvfi_rd_wdata,
    input  logic [NRET*XLEN-1:0] rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0] rvfi_rs2_rdata,
    output logic [NRET-1:0]    rs1_mis,
    output logic [NRET-1:0]    rs2_mis,
    output logic [NRET*XLEN-1:0] exp_data
);

    logic [XLEN-1:0] data_q;
    logic            written_q;
    logic [XLEN-1:0] cur;
    logic            cur_ok;
    logic            en;

    // Reads of a channel see writes of older channels, never their own.
    always_comb begin
        cur      = data_q;
        cur_ok   = written_q;
        rs1_mis  = '0;
        rs2_mis  = '0;
        exp_data = '0;
        en       = (idx != REG_X0);
        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid[k]) begin
                exp_data[k*XLEN +: XLEN] = cur;
                rs1_mis[k] = en && cur_ok
                    && (rvfi_rs1_addr[k*5 +: 5] == idx)
                    && (rvfi_rs1_rdata[k*XLEN +: XLEN] != cur);
                rs2_mis[k] = en && cur_ok
                    && (rvfi_rs2_addr[k*5 +: 5] == idx)
                    && (rvfi_rs2_rdata[k*XLEN +: XLEN] != cur);
                if (rvfi_rd_addr[k*5 +: 5] == idx) begin
                    cur    = rvfi_rd_wdata[k*XLEN +: XLEN];
                    cur_ok = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= 1'b0;
        end else begin
            written_q <= cur_ok;
            data_q    <= cur;
        end
    end

endmodule

// File: rtl/rvfi_regfile_checker.sv
// RVFI register-file checker: shadow trackers, x0 rule, first-failure capture.
// Define RVFI_CHECK_ASSERT_EN to compile in formal assumptions/assertions.
module rvfi_regfile_checker
    import rvfi_check_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NRET   = 1,
    parameter int NTRACK = 2,
    localparam int CW    = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET*5-1:0]    rvfi_rd_addr,
    input  logic [NRET*5-1:0]    rvfi_rs1_addr,
    input  logic [NRET*5-1:0]    rvfi_rs2_addr,
    input  logic [NRET*XLEN-1:0] rvfi_rd_wdata,
    input  logic [NRET*XLEN-1:0] rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0] rvfi_rs2_rdata,
    input  logic [NTRACK*5-1:0]  track_idx,
    output logic                 err,
    output logic [NTRACK-1:0]    err_track,
    output logic                 err_x0,
    output logic [CW-1:0]        first_chan,
    output logic [4:0]           first_idx,
    output logic [XLEN-1:0]      first_exp,
    output logic [XLEN-1:0]      first_got,
    output logic [1:0]           state
);

    logic [NRET-1:0]      rs1_mis [NTRACK];
    logic [NRET-1:0]      rs2_mis [NTRACK];
    logic [NRET*XLEN-1:0] exp_d   [NTRACK];

    for (genvar t = 0; t < NTRACK; t++) begin : g_trk
        rvfi_shadow_reg #(
            .XLEN (XLEN),
            .NRET (NRET)
        ) u_shadow (
            .clk            (clk),
            .rst            (rst),
            .idx            (track_idx[t*5 +: 5]),
            .rvfi_valid     (rvfi_valid),
            .rvfi_rd_addr   (rvfi_rd_addr),
            .rvfi_rs1_addr  (rvfi_rs1_addr),
            .rvfi_rs2_addr  (rvfi_rs2_addr),
            .rvfi_rd_wdata  (rvfi_rd_wdata),
            .rvfi_rs1_rdata (rvfi_rs1_rdata),
            .rvfi_rs2_rdata (rvfi_rs2_rdata),
            .rs1_mis        (rs1_mis[t]),
            .rs2_mis        (rs2_mis[t]),
            .exp_data       (exp_d[t])
        );
    end

    logic [NTRACK-1:0] trk_hit;
    logic              x0_hit;
    logic              hit;
    logic [CW-1:0]     cap_chan;
    regaddr_t          cap_idx;
    logic [XLEN-1:0]   cap_exp;
    logic [XLEN-1:0]   cap_got;
    regaddr_t          a1, a2, ar;
    logic [XLEN-1:0]   d1, d2, dr;
    logic              x1, x2, xr;

    // Walk channels oldest first; the first hit found is the captured one.
    always_comb begin
        trk_hit  = '0;
        x0_hit   = 1'b0;
        hit      = 1'b0;
        cap_chan = '0;
        cap_idx  = '0;
        cap_exp  = '0;
        cap_got  = '0;
        a1 = '0; a2 = '0; ar = '0;
        d1 = '0; d2 = '0; dr = '0;
        x1 = 1'b0; x2 = 1'b0; xr = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            a1 = rvfi_rs1_addr[k*5 +: 5];
            a2 = rvfi_rs2_addr[k*5 +: 5];
            ar = rvfi_rd_addr[k*5 +: 5];
            d1 = rvfi_rs1_rdata[k*XLEN +: XLEN];
            d2 = rvfi_rs2_rdata[k*XLEN +: XLEN];
            dr = rvfi_rd_wdata[k*XLEN +: XLEN];
            x1 = rvfi_valid[k] && (a1 == REG_X0) && (d1 != '0);
            x2 = rvfi_valid[k] && (a2 == REG_X0) && (d2 != '0);
            xr = rvfi_valid[k] && (ar == REG_X0) && (dr != '0);
            x0_hit = x0_hit | x1 | x2 | xr;
            for (int t = 0; t < NTRACK; t++) begin
                trk_hit[t] = trk_hit[t] | rs1_mis[t][k] | rs2_mis[t][k];
            end
            if (!hit && x1) begin
                hit = 1'b1; cap_chan = CW'(k); cap_idx = a1;
                cap_exp = '0; cap_got = d1;
            end
            for (int t = 0; t < NTRACK; t++) begin
                if (!hit && rs1_mis[t][k]) begin
                    hit = 1'b1; cap_chan = CW'(k); cap_idx = a1;
                    cap_exp = exp_d[t][k*XLEN +: XLEN]; cap_got = d1;
                end
            end
            if (!hit && x2) begin
                hit = 1'b1; cap_chan = CW'(k); cap_idx = a2;
                cap_exp = '0; cap_got = d2;
            end
            for (int t = 0; t < NTRACK; t++) begin
                if (!hit && rs2_mis[t][k]) begin
                    hit = 1'b1; cap_chan = CW'(k); cap_idx = a2;
                    cap_exp = exp_d[t][k*XLEN +: XLEN]; cap_got = d2;
                end
            end
            if (!hit && xr) begin
                hit = 1'b1; cap_chan = CW'(k); cap_idx = ar;
                cap_exp = '0; cap_got = dr;
            end
        end
    end

    chk_state_e state_q, state_d;
    logic       capture;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = FAILED;
                    capture = 1'b1;
                end else if (|rvfi_valid) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (hit) begin
                    state_d = FAILED;
                    capture = 1'b1;
                end
            end
            FAILED: state_d = FAILED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            err_track  <= '0;
            err_x0     <= 1'b0;
            first_chan <= '0;
            first_idx  <= '0;
            first_exp  <= '0;
            first_got  <= '0;
        end else begin
            state_q   <= state_d;
            err_track <= err_track | trk_hit;
            err_x0    <= err_x0 | x0_hit;
            if (capture) begin
                first_chan <= cap_chan;
                first_idx  <= cap_idx;
                first_exp  <= cap_exp;
                first_got  <= cap_got;
            end
        end
    end

    assign err   = (|err_track) | err_x0;
    assign state = state_q;

`ifdef RVFI_CHECK_ASSERT_EN
    logic past_q;

    always_ff @(posedge clk) begin
        if (rst) past_q <= 1'b0;
        else     past_q <= 1'b1;
    end

    idx_stable: assume property (@(posedge clk) past_q |-> $stable(track_idx));

    for (genvar t = 0; t < NTRACK; t++) begin : g_fv
        idx_nz: assume property (@(posedge clk) track_idx[t*5 +: 5] != REG_X0);
        trk_ok: assert property (@(posedge clk) disable iff (rst) !err_track[t]);
    end

    x0_ok: assert property (@(posedge clk) disable iff (rst) !err_x0);
`endif

endmodule

// File: doc/rvfi_regfile_checker.md
# rvfi_regfile_checker

Parametrised RVFI register-file consistency checker bound into `ibex_top` alongside the core's RVFI trace port. It shadows `NTRACK` architectural registers selected by free index inputs, checks every `rs1`/`rs2` read against the last value written, and enforces x0 as hard-zero. It handles `NRET` retirement channels per cycle with in-cycle forwarding, and captures the first failure for debug. It runs in formal, where the indices are free and held stable, and in simulation, where the bench drives the indices.

## Interface
Parameters:
- `XLEN`, 32, register data width
- `NRET`, 1, retirement channels per cycle; channel 0 is oldest
- `NTRACK`, 2, number of independently shadowed registers

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `rvfi_valid`  in  NRET  per-channel retire strobe
- `rvfi_rd_addr` / `rvfi_rs1_addr` / `rvfi_rs2_addr`  in  NRET*5  packed addresses, channel k at [5k+:5]
- `rvfi_rd_wdata` / `rvfi_rs1_rdata` / `rvfi_rs2_rdata`  in  NRET*XLEN  packed data
- `track_idx`  in  NTRACK*5  register index per tracker; 0 disables that tracker
- `err`  out  1  sticky OR of all error sources
- `err_track`  out  NTRACK  sticky per-tracker mismatch flags
- `err_x0`  out  1  sticky x0 violation flag
- `first_chan` / `first_idx`  out  clog2(NRET) / 5  channel and register of the first failure
- `first_exp` / `first_got`  out  XLEN  expected and observed data of the first failure
- `state`  out  2  capture FSM state

## Operation
- Per tracker t, keep `data[t]` (XLEN) and `written[t]`.
- Channels are processed in order 0 to NRET-1 within a cycle.
- Checks for channel k with `rvfi_valid[k]` set:
  - Reads are checked before the channel's own write. If rd==rs1==idx on the same channel, rs1 is compared against the prior value.
  - The expected value for channel k is the last write to idx on a valid channel j<k in the same cycle. If there is none, it is `data[t]`.
  - The check applies only when `written[t]` is set or an earlier same-cycle write exists.
  - rs1 and rs2 are checked independently. Both may flag in one cycle.
  - A write to idx by several channels in one cycle: the highest channel wins for `data[t]`.
- x0 rule: `rd_addr==0` with nonzero `rd_wdata`, or `rs1/rs2_addr==0` with nonzero rdata, sets `err_x0`. The x0 rule applies regardless of trackers.
- Invalid channels (`rvfi_valid[k]`=0) are ignored entirely.
- A tracker with `track_idx`==0 never sets its flag.
- Capture FSM:
  - States: IDLE(0), ARMED(1), FAILED(2).
  - Reset moves to IDLE.
  - The first valid retirement moves IDLE to ARMED.
  - Any error in ARMED moves to FAILED and latches `first_*`.
  - FAILED is terminal until reset.
- First-failure priority when several errors occur in the same cycle:
  - lowest channel first;
  - then rs1 before rs2;
  - then the x0 check;
  - then the lowest tracker.
- For an x0 failure, `first_exp` reports 0.
- A failure on the very first retirement goes IDLE to FAILED directly.

## Timing
- Error flags and `first_*` are registered and assert on the cycle after the offending retirement edge (1-cycle latency).
- Reset values:
  - `err`, `err_track`, `err_x0`: 0
  - `first_*`: 0
  - `state`: IDLE
  - `written`: 0
  - `data`: don't-care, not observable
- Reset mid-operation: all shadows are invalidated. The first read after reset of a tracked register is unchecked until it is rewritten.
- Flags are sticky. Only `rst` clears them.
- `track_idx` changes are honoured immediately in simulation. Shadows are not cleared on a change, so a bench must reset after changing indices.

## Configuration
- `RVFI_CHECK_ASSERT_EN` defined: the block compiles in concurrent properties:
  - assume `track_idx` stable after the first cycle;
  - assume each `track_idx` != 0;
  - assert `err_track[t]`==0 for each t;
  - assert `err_x0`==0.
- Macro undefined: the block is purely synthesizable/simulatable, with the flag outputs only and no assumptions or assertions.

## Structure
- Package `rvfi_check_pkg`:
  - `regaddr_t` (logic [4:0]);
  - state enum `chk_state_e` {IDLE, ARMED, FAILED};
  - localparam `REG_X0`=5'd0.
- Sub-module `rvfi_shadow_reg`, one instance per tracker:
  - holds `data`/`written`;
  - performs the forwarding scan over channels;
  - outputs per-channel rs1/rs2 mismatch bits plus the expected value.
- Top level handles the x0 checks, priority encoding, and the capture FSM.

## Test plan
- NRET=1, idx=7: write x7=0xDEADBEEF, later read rs1=x7 with 0xDEADBEEF → no error; read rs2=x7 with 0xDEADBEEE → `err_track[0]`=1 next cycle, `first_exp`=0xDEADBEEF, `first_got`=0xDEADBEEE, state=FAILED.
- Read x7=0x1234 before any write → no error; then write 0x5 and read 0x5 → no error.
- NRET=2, idx=3: ch0 writes x3=0xA, ch1 reads x3=0xA in the same cycle → no error; ch1 reads 0xB → error with `first_chan`=1.
- rd=x0 with wdata=0x1 → `err_x0`=1, `first_idx`=0, `first_exp`=0; rs1=x0 with rdata=0 → no error.
- Write x7=0x9, assert `rst` for 1 cycle, read x7=0x0 → no error, state IDLE then ARMED.
- Errors on ch0.rs2 and ch1.rs1 in the same cycle → `first_chan`=0, and the ch0 rs2 values are captured.
